md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage of the pipelined MIPS core. It sits beside the ALU and receives the same forwarded operands A/B.
- Owns the architectural HI/LO registers and runs mult/multu/div/divu over a fixed latency.
- Exposes busy so the hazard unit can stall the next HI/LO-touching instruction.
- Also serves mfhi/mflo reads and mthi/mtlo writes.

---
 rtl/md_unit.sv | 167 ++++++++++++++++
 tb/tb_md_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit owning HI/LO; fixed-latency mult/div with registered busy.
// Optional MADD/MADDU/MSUB accumulate ops are enabled by defining MDU_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        start,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
`endif

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic          r_pend_we;
  logic          w_commit, w_accept, w_is_div, w_start_class, w_mt_ok;
  logic [31:0]   w_pend_hi, w_pend_lo;
  logic          w_pend_we;

  logic [63:0]   w_prod_s, w_prod_u;
  logic [31:0]   w_a_abs, w_b_abs, w_dividend, w_divisor, w_q, w_r;
  logic          w_div_signed;

  assign w_is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);

  always_comb begin
    w_start_class = 1'b0;
    case (MDOp)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_start_class = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB:         w_start_class = 1'b1;
`endif
      default:                            w_start_class = 1'b0;
    endcase
  end

  assign busy     = (r_state == S_RUN);
  assign w_accept = start & ~req & ~busy & w_start_class;
  assign w_mt_ok  = ~req & ~busy & ~start;

  // Operands widened to 64 bits so the truncated product is the exact result.
  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow corner
  // and gives truncation toward zero with remainder taking the dividend sign.
  assign w_div_signed = (MDOp == OP_DIV);
  assign w_a_abs      = A[31] ? (~A + 32'd1) : A;
  assign w_b_abs      = B[31] ? (~B + 32'd1) : B;
  assign w_dividend   = w_div_signed ? w_a_abs : A;
  assign w_divisor    = (B == 32'd0) ? 32'd1 : (w_div_signed ? w_b_abs : B);
  assign w_q          = w_dividend / w_divisor;
  assign w_r          = w_dividend % w_divisor;

  always_comb begin
    w_pend_hi = w_prod_s[63:32];
    w_pend_lo = w_prod_s[31:0];
    w_pend_we = 1'b1;
    case (MDOp)
      OP_MULTU: {w_pend_hi, w_pend_lo} = w_prod_u;
      OP_DIV: begin
        w_pend_lo = (A[31] ^ B[31]) ? (~w_q + 32'd1) : w_q;
        w_pend_hi = A[31] ? (~w_r + 32'd1) : w_r;
        w_pend_we = (B != 32'd0);
      end
      OP_DIVU: begin
        w_pend_lo = w_q;
        w_pend_hi = w_r;
        w_pend_we = (B != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {w_pend_hi, w_pend_lo} = {r_hi, r_lo} + w_prod_s;
      OP_MADDU: {w_pend_hi, w_pend_lo} = {r_hi, r_lo} + w_prod_u;
      OP_MSUB:  {w_pend_hi, w_pend_lo} = {r_hi, r_lo} - w_prod_s;
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_commit    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_pend_hi <= w_pend_hi;
        r_pend_lo <= w_pend_lo;
        r_pend_we <= w_pend_we;
      end
      // Commit only happens while busy, and MT* writes only while idle.
      if (w_commit) begin
        if (r_pend_we) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else if (w_mt_ok && (MDOp == OP_MTHI)) begin
        r_hi <= A;
      end else if (w_mt_ok && (MDOp == OP_MTLO)) begin
        r_lo <= A;
      end
    end
  end

  assign HI  = r_hi;
  assign LO  = r_lo;
  assign out = (MDOp == OP_MFHI) ? r_hi : (MDOp == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of mult/div vectors plus hand sequences for
// MT*/MF*, req, start-while-busy, reset abort and the optional accumulate ops.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDOp;
  logic        start, req;
  logic        busy;
  logic [31:0] HI, LO, out;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;
  localparam logic [3:0] MADD = 4'd9, MADDU = 4'd10, MSUB = 4'd11;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .start(start),
    .req(req), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accepts one op at the next edge, then counts busy cycles (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    MDOp = op; A = a; B = b; start = 1'b1; req = 1'b0;
    @(negedge clk);
    start = 1'b0; MDOp = NONE;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic r);
    @(negedge clk);
    MDOp = op; A = a; start = 1'b0; req = r;
    @(negedge clk);
    MDOp = NONE; req = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{"mult_neg",   MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{"multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{"div_m7_2",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"divu_100_7", DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[4] = '{"div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
    vecs[5] = '{"div_7_m2",   DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[6] = '{"mult_min2",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    reset = 1'b1; A = '0; B = '0; MDOp = NONE; start = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out", out, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk({vecs[i].name, "_busy_cycles"}, n, vecs[i].n);
      chk({vecs[i].name, "_hi"}, HI, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, LO, vecs[i].lo);
    end

    // MT* then divide by zero leaves HI/LO untouched
    mt(MTHI, 32'h1234, 1'b0);
    mt(MTLO, 32'h5678, 1'b0);
    chk("mthi", HI, 32'h1234);
    chk("mtlo", LO, 32'h5678);
    run_op(DIVU, 32'd99, 32'd0, n);
    chk("div0_busy_cycles", n, 10);
    chk("div0_hi", HI, 32'h1234);
    chk("div0_lo", LO, 32'h5678);

    MDOp = MFLO; #1;
    chk("mflo_out", out, 32'h5678);
    MDOp = MFHI; #1;
    chk("mfhi_out", out, 32'h1234);
    MDOp = NONE; #1;
    chk("none_out", out, 32'd0);

    // start and MTLO suppressed by req
    @(negedge clk);
    MDOp = MULT; A = 32'd2; B = 32'd3; start = 1'b1; req = 1'b1;
    @(negedge clk);
    start = 1'b0; req = 1'b0; MDOp = NONE;
    chk("req_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("req_start_hi", HI, 32'h1234);
    chk("req_start_lo", LO, 32'h5678);
    mt(MTLO, 32'hABCD, 1'b1);
    chk("req_mtlo_lo", LO, 32'h5678);

    // Second start during busy cycle 3 must be ignored
    @(negedge clk);
    MDOp = DIV; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 3) begin
        start = 1'b1; MDOp = MULT; A = 32'd2; B = 32'd3;
      end else begin
        start = 1'b0; MDOp = NONE;
      end
      @(negedge clk);
    end
    start = 1'b0; MDOp = NONE;
    chk("restart_busy_cycles", n, 10);
    chk("restart_hi", HI, 32'd2);
    chk("restart_lo", LO, 32'd14);

    // Reset at busy cycle 6 aborts without commit
    @(negedge clk);
    MDOp = DIVU; A = 32'd50; B = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDOp = NONE;
    n = 0;
    while (busy && n < 5) begin
      n++;
      @(negedge clk);
    end
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_commit_lo", LO, 32'd0);

`ifdef MDU_MADD_EN
    mt(MTHI, 32'd0, 1'b0);
    mt(MTLO, 32'hFFFFFFFF, 1'b0);
    run_op(MADDU, 32'd1, 32'd1, n);
    chk("maddu_busy_cycles", n, 5);
    chk("maddu_hi", HI, 32'd1);
    chk("maddu_lo", LO, 32'd0);
    mt(MTHI, 32'd0, 1'b0);
    mt(MTLO, 32'd0, 1'b0);
    run_op(MSUB, 32'd1, 32'd2, n);
    chk("msub_busy_cycles", n, 5);
    chk("msub_hi", HI, 32'hFFFFFFFF);
    chk("msub_lo", LO, 32'hFFFFFFFE);
`else
    mt(MTHI, 32'd0, 1'b0);
    mt(MTLO, 32'hFFFFFFFF, 1'b0);
    run_op(MADDU, 32'd1, 32'd1, n);
    chk("maddu_off_busy_cycles", n, 0);
    chk("maddu_off_hi", HI, 32'd0);
    chk("maddu_off_lo", LO, 32'hFFFFFFFF);
    run_op(MSUB, 32'd1, 32'd2, n);
    chk("msub_off_busy_cycles", n, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
